// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: 8N1/8N2 framing with fully registered outputs.
// Optional even-parity bit is enabled by defining UART_TX_PARITY_EN.
module uart_tx_serializer #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_start,
  output logic       o_tx_start_clear,
  output logic       o_busy,
  output logic       o_tx
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] BAUD_ONE  = CNT_W'(1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_e;
`endif

  state_e           state_q;
  logic [CNT_W-1:0] baud_cnt_q;
  logic [2:0]       bit_idx_q;
  logic             stop_idx_q;
  logic [7:0]       data_q;
  logic             tx_q;
  logic             busy_q;
  logic             clr_q;

  wire baud_done = (baud_cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: every register, the data latch included, is cleared asynchronously so an aborted byte cannot leak into the next frame.
      state_q    <= ST_IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      data_q     <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      clr_q      <= 1'b0;
    end else begin
      clr_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          if (i_tx_start) begin
            data_q     <= i_tx_data;
            state_q    <= ST_START;
            tx_q       <= 1'b0;
            busy_q     <= 1'b1;
            clr_q      <= 1'b1;
            baud_cnt_q <= BAUD_LAST;
          end
        end

        ST_START: begin
          if (baud_done) begin
            state_q    <= ST_DATA;
            tx_q       <= data_q[0];
            bit_idx_q  <= '0;
            baud_cnt_q <= BAUD_LAST;
          end else begin
            baud_cnt_q <= baud_cnt_q - BAUD_ONE;
          end
        end

        ST_DATA: begin
          if (baud_done) begin
            baud_cnt_q <= BAUD_LAST;
            if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state_q <= ST_PARITY;
              tx_q    <= ^data_q;
`else
              state_q    <= ST_STOP;
              tx_q       <= 1'b1;
              stop_idx_q <= 1'b0;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              tx_q      <= data_q[bit_idx_q + 3'd1];
            end
          end else begin
            baud_cnt_q <= baud_cnt_q - BAUD_ONE;
          end
        end

`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (baud_done) begin
            state_q    <= ST_STOP;
            tx_q       <= 1'b1;
            stop_idx_q <= 1'b0;
            baud_cnt_q <= BAUD_LAST;
          end else begin
            baud_cnt_q <= baud_cnt_q - BAUD_ONE;
          end
        end
`endif

        ST_STOP: begin
          tx_q <= 1'b1;
          if (baud_done) begin
            baud_cnt_q <= BAUD_LAST;
            if (stop_idx_q == STOP_LAST) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              stop_idx_q <= 1'b1;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q - BAUD_ONE;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_tx             = tx_q;
  assign o_busy           = busy_q;
  assign o_tx_start_clear = clr_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer at CLKS_PER_BIT=4; builds with or
// without UART_TX_PARITY_EN (parity build uses STOP_BITS=2).
module tb_uart_tx_serializer;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int STOPB = 2;
  localparam int FRAME = 48;
`else
  localparam int STOPB = 1;
  localparam int FRAME = 40;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] i_tx_data = 8'h00;
  logic       i_tx_start = 1'b0;
  logic       o_tx_start_clear;
  logic       o_busy;
  logic       o_tx;

  int n_checks = 0;
  int n_fail = 0;
  int clr_pulses = 0;
  int last_busy_cnt = 0;
  logic tx_log [0:63];

  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .STOP_BITS(STOPB)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_tx_data        (i_tx_data),
    .i_tx_start       (i_tx_start),
    .o_tx_start_clear (o_tx_start_clear),
    .o_busy           (o_busy),
    .o_tx             (o_tx)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (o_tx_start_clear === 1'b1) clr_pulses++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Expected line level for bit slot s of a frame carrying byte b.
  function automatic logic exp_bit(input logic [7:0] b, input int s);
    if (s == 0) return 1'b0;
    if (s <= 8) return b[s-1];
`ifdef UART_TX_PARITY_EN
    if (s == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Starts a frame from an idle DUT (called just after a falling edge) and
  // checks every cycle through the first idle sample after o_busy falls.
  task automatic run_frame(input logic [7:0] b, input bit hold, input string tag);
    int busy_cnt;
    busy_cnt = 0;
    i_tx_data  = b;
    i_tx_start = 1'b1;
    for (int i = 0; i <= FRAME; i++) begin
      @(negedge clk);
      tx_log[i] = o_tx;
      if (o_busy === 1'b1) busy_cnt++;
      if (i == 0 && !hold) i_tx_start = 1'b0;
      if (i < FRAME) begin
        n_checks++;
        if (o_tx !== exp_bit(b, i / CPB)) begin
          n_fail++;
          $display("FAIL %s tx cyc%0d: got %b want %b", tag, i, o_tx, exp_bit(b, i / CPB));
        end
        n_checks++;
        if (o_busy !== 1'b1) begin
          n_fail++;
          $display("FAIL %s busy cyc%0d: got %b want 1", tag, i, o_busy);
        end
        n_checks++;
        if (o_tx_start_clear !== logic'(i == 0)) begin
          n_fail++;
          $display("FAIL %s clear cyc%0d: got %b want %b", tag, i, o_tx_start_clear, (i == 0));
        end
      end else begin
        n_checks++;
        if (o_busy !== 1'b0 || o_tx !== 1'b1 || o_tx_start_clear !== 1'b0) begin
          n_fail++;
          $display("FAIL %s end: busy=%b tx=%b clr=%b want 0/1/0", tag, o_busy, o_tx, o_tx_start_clear);
        end
      end
    end
    last_busy_cnt = busy_cnt;
  endtask

  task automatic test_reset;
    i_tx_start = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (o_tx !== 1'b1 || o_busy !== 1'b0 || o_tx_start_clear !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: tx=%b busy=%b clr=%b want 1/0/0", o_tx, o_busy, o_tx_start_clear);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_idle;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      n_checks++;
      if (o_tx !== 1'b1 || o_busy !== 1'b0 || o_tx_start_clear !== 1'b0) begin
        n_fail++;
        $display("FAIL idle cyc%0d: tx=%b busy=%b clr=%b want 1/0/0", i, o_tx, o_busy, o_tx_start_clear);
      end
    end
  endtask

  task automatic test_basic_55;
    logic [9:0] pat;
    int start_pulses;
    pat = 10'b1010101010;
    start_pulses = clr_pulses;
    run_frame(8'h55, 1'b0, "b55");
    for (int s = 0; s < 9; s++) begin
      n_checks++;
      if (tx_log[s*CPB + 2] !== pat[s]) begin
        n_fail++;
        $display("FAIL b55 slot%0d: got %b want %b", s, tx_log[s*CPB + 2], pat[s]);
      end
    end
    n_checks++;
`ifdef UART_TX_PARITY_EN
    if (last_busy_cnt != 48) begin
      n_fail++;
      $display("FAIL b55 busy_len: got %0d want 48", last_busy_cnt);
    end
`else
    if (last_busy_cnt != 40) begin
      n_fail++;
      $display("FAIL b55 busy_len: got %0d want 40", last_busy_cnt);
    end
`endif
    n_checks++;
    if (clr_pulses - start_pulses != 1) begin
      n_fail++;
      $display("FAIL b55 clr_count: got %0d want 1", clr_pulses - start_pulses);
    end
  endtask

  task automatic test_hold_start;
    int waited;
    run_frame(8'h81, 1'b1, "hold");
    @(negedge clk);
    n_checks++;
    if (o_tx_start_clear !== 1'b1 || o_busy !== 1'b1 || o_tx !== 1'b0) begin
      n_fail++;
      $display("FAIL hold reaccept: clr=%b busy=%b tx=%b want 1/1/0", o_tx_start_clear, o_busy, o_tx);
    end
    i_tx_start = 1'b0;
    waited = 0;
    while (o_busy === 1'b1 && waited < FRAME + 8) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (waited != FRAME) begin
      n_fail++;
      $display("FAIL hold second_len: got %0d want %0d", waited, FRAME);
    end
    @(negedge clk);
    n_checks++;
    if (o_busy !== 1'b0 || o_tx_start_clear !== 1'b0) begin
      n_fail++;
      $display("FAIL hold after: busy=%b clr=%b want 0/0", o_busy, o_tx_start_clear);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] word;
    int start_pulses;
    word = 32'hDEAD_3CA5;
    start_pulses = clr_pulses;
    run_frame(word[7:0], 1'b0, "b2b_a5");
    run_frame(word[15:8], 1'b0, "b2b_3c");
    n_checks++;
    if (clr_pulses - start_pulses != 2) begin
      n_fail++;
      $display("FAIL b2b clr_count: got %0d want 2", clr_pulses - start_pulses);
    end
  endtask

  task automatic test_reset_mid_frame;
    i_tx_data  = 8'h00;
    i_tx_start = 1'b1;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      if (i == 0) i_tx_start = 1'b0;
      n_checks++;
      if (o_tx !== 1'b0 || o_busy !== 1'b1) begin
        n_fail++;
        $display("FAIL rstmid pre cyc%0d: tx=%b busy=%b want 0/1", i, o_tx, o_busy);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (o_tx !== 1'b1 || o_busy !== 1'b0 || o_tx_start_clear !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid async: tx=%b busy=%b clr=%b want 1/0/0", o_tx, o_busy, o_tx_start_clear);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (o_tx !== 1'b1 || o_busy !== 1'b0) begin
        n_fail++;
        $display("FAIL rstmid post cyc%0d: tx=%b busy=%b want 1/0", i, o_tx, o_busy);
      end
    end
    run_frame(8'h5A, 1'b0, "after_rst");
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity;
    run_frame(8'h07, 1'b0, "par07");
    for (int i = 36; i < 40; i++) begin
      n_checks++;
      if (tx_log[i] !== 1'b1) begin
        n_fail++;
        $display("FAIL par07 parity cyc%0d: got %b want 1", i, tx_log[i]);
      end
    end
    for (int i = 40; i < 48; i++) begin
      n_checks++;
      if (tx_log[i] !== 1'b1) begin
        n_fail++;
        $display("FAIL par07 stop cyc%0d: got %b want 1", i, tx_log[i]);
      end
    end
    n_checks++;
    if (last_busy_cnt != 48) begin
      n_fail++;
      $display("FAIL par07 frame_len: got %0d want 48", last_busy_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_idle();
    test_basic_55();
    test_hold_start();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, meaning clk cycles per serial bit (legal range 2..65535).
REQ-002 SHALL have parameter STOP_BITS, default 1, meaning number of stop bits per frame (legal values 1 or 2).
REQ-003 SHALL have port clk  input  1  system clock; all logic is on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_tx_data  input  8  byte to transmit; sampled only at accept.
REQ-006 SHALL have port i_tx_start  input  1  level request from the upstream byte feeder; held high until cleared.
REQ-007 SHALL have port o_tx_start_clear  output  1  one-cycle pulse acknowledging that the byte was accepted.
REQ-008 SHALL have port o_busy  output  1  high while a frame is in flight.
REQ-009 SHALL have port o_tx  output  1  serial line; idle high.

Function
REQ-010 SHALL implement states IDLE, START, DATA, PARITY (only with the macro in REQ-027), and STOP, all registered.
REQ-011 SHALL accept the byte on a rising edge where state==IDLE and i_tx_start==1: latch i_tx_data, go to START, set o_busy=1, o_tx=0 and o_tx_start_clear=1 on that edge.
REQ-012 SHALL drive o_tx_start_clear high for exactly one cycle per accepted byte, and never while i_tx_start is low.
REQ-013 SHALL hold each bit on o_tx for exactly CLKS_PER_BIT cycles, timed by a baud counter of width clog2(CLKS_PER_BIT) that reloads at every bit boundary.
REQ-014 SHALL transmit the 8 data bits LSB first after the start bit, using a 3-bit index that advances from 0 to 7; DATA exits when index 7 expires.
REQ-015 SHALL drive o_tx=1 for STOP_BITS*CLKS_PER_BIT cycles in STOP, then go to IDLE with o_busy=0.
REQ-016 SHALL ignore i_tx_start and i_tx_data whenever state!=IDLE, so a request held high during a frame is not double-accepted.
REQ-017 SHALL leave at least one IDLE cycle between frames: o_busy is 0 for at least one cycle before the next accept.
REQ-018 SHALL make the frame length (1+8+STOP_BITS)*CLKS_PER_BIT cycles, plus CLKS_PER_BIT when parity is enabled, measured from the accept edge to the o_busy fall.
REQ-019 SHALL be driven entirely by registered outputs; no combinational path from inputs to o_tx, o_busy or o_tx_start_clear.
REQ-020 SHALL return to IDLE from any illegal state encoding, with o_tx=1 and o_busy=0.
REQ-021 SHALL, in IDLE with i_tx_start low, hold o_tx=1, o_busy=0 and o_tx_start_clear=0 indefinitely.

Reset
REQ-022 SHALL, while rst_n is low, force state=IDLE, o_tx=1, o_busy=0, o_tx_start_clear=0, and clear the baud counter, bit index and data latch, regardless of clk.
REQ-023 SHALL abort a frame in progress on reset: o_tx goes high immediately with no partial stop bit, and the byte is lost.
REQ-024 SHALL, after rst_n rises, accept no byte earlier than the first rising edge on which i_tx_start is sampled high.

Configuration
REQ-025 SHALL use macro UART_TX_PARITY_EN.
REQ-026 SHALL, without UART_TX_PARITY_EN, contain no PARITY state and go directly from DATA to STOP.
REQ-027 SHALL, with UART_TX_PARITY_EN, insert a PARITY state between DATA and STOP that drives the even parity of the latched byte (XOR of its 8 bits) for CLKS_PER_BIT cycles.

Verification
REQ-028 SHALL cover: CLKS_PER_BIT=4, STOP_BITS=1, no parity, byte 0x55 -> o_tx samples 0,1,0,1,0,1,0,1,0,1 with 4 cycles each, o_busy high for 40 cycles, one o_tx_start_clear pulse on the accept edge.
REQ-029 SHALL cover: i_tx_start held high for a whole frame and beyond (feeder not yet clearing) -> exactly one accept per frame, next accept exactly one cycle after the o_busy fall.
REQ-030 SHALL cover: back-to-back bytes 0xA5, 0x3C from a 4-byte word feeder -> both bytes appear LSB first, the inter-frame o_busy low time is at least 1 cycle, two clear pulses.
REQ-031 SHALL cover: rst_n asserted at cycle 13 of a 0x00 frame -> o_tx=1 and o_busy=0 with no clk edge, and the next byte sent correctly after release.
REQ-032 SHALL cover: UART_TX_PARITY_EN with STOP_BITS=2 and byte 0x07 -> parity bit 1 after the data bits, stop high for 8 cycles, frame length 48 cycles.
